// File: rtl/ink_bbox_scanner_if.sv
// Handshake bundle between the frame buffer, the bbox scanner and the crop stage.
// Slave side is the scanner; master side is whatever feeds rows and consumes the box.
interface ink_bbox_scanner_if #(
    parameter int COLS  = 28,
    parameter int IDX_W = 5
);
    logic             Start;
    logic             Row_Valid;
    logic             Row_Ready;
    logic [COLS-1:0]  Row_Bits;
    logic             Box_Valid;
    logic             Box_Ready;
    logic [IDX_W-1:0] Row_Min;
    logic [IDX_W-1:0] Row_Max;
    logic [IDX_W-1:0] Col_Min;
    logic [IDX_W-1:0] Col_Max;
    logic             Empty;
    logic             Busy;

    modport master (
        output Start, Row_Valid, Row_Bits, Box_Ready,
        input  Row_Ready, Box_Valid, Row_Min, Row_Max, Col_Min, Col_Max, Empty, Busy
    );

    modport slave (
        input  Start, Row_Valid, Row_Bits, Box_Ready,
        output Row_Ready, Box_Valid, Row_Min, Row_Max, Col_Min, Col_Max, Empty, Busy
    );
endinterface

// File: rtl/ink_bbox_scanner.sv
// Ink bounding-box scanner: accepts one frame row per cycle, tracks the first and
// last inked row on the fly and ORs every row into a column accumulator, then walks
// that accumulator one column per cycle to find the first/last inked column.
// The box is then held behind Box_Valid/Box_Ready until the crop stage takes it.
module ink_bbox_scanner #(
    parameter int COLS  = 28,
    parameter int ROWS  = 28,
    parameter int IDX_W = 5
) (
    input  logic GlobalClock,
    input  logic Reset_n,
    ink_bbox_scanner_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COLS - 1);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] row_cnt;
    logic [IDX_W-1:0] col_cnt;
    logic [COLS-1:0]  col_acc;
    logic             seen;
    logic             col_seen;

    logic             start_frame;
    logic             row_acc;
    logic             row_any;
    logic             col_bit;
    logic             last_col;

    // Row_Ready is a registered copy of "in SCAN", so acceptance needs no state decode.
    assign start_frame = (state == IDLE) && bus.Start;
    assign row_acc     = bus.Row_Valid && bus.Row_Ready;
    assign row_any     = |bus.Row_Bits;
    assign col_bit     = col_acc[col_cnt];
    assign last_col    = (col_cnt == LAST_COL);

    // Next-state decode; Start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.Start) state_nxt = SCAN;
            SCAN: if (row_acc && (row_cnt == LAST_ROW)) state_nxt = FIND;
            FIND: if (last_col) state_nxt = DONE;
            DONE: if (bus.Box_Valid && bus.Box_Ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and handshake/status outputs, registered from the next state
    // so they line up with the state they describe.
    always_ff @(posedge GlobalClock or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            bus.Row_Ready <= 1'b0;
            bus.Box_Valid <= 1'b0;
            bus.Busy      <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus.Row_Ready <= (state_nxt == SCAN);
            bus.Box_Valid <= (state_nxt == DONE);
            bus.Busy      <= (state_nxt != IDLE);
        end
    end

    // Row pass: count rows, fold each row into col_acc, capture first/last inked row.
    // Row indices are cleared at the end of FIND when nothing was inked.
    always_ff @(posedge GlobalClock or negedge Reset_n) begin
        if (!Reset_n) begin
            row_cnt     <= '0;
            col_acc     <= '0;
            seen        <= 1'b0;
            bus.Row_Min <= '0;
            bus.Row_Max <= '0;
        end else if (start_frame) begin
            row_cnt <= '0;
            col_acc <= '0;
            seen    <= 1'b0;
        end else if (row_acc) begin
            col_acc <= col_acc | bus.Row_Bits;
            if (row_any && !seen) begin
                bus.Row_Min <= row_cnt;
                seen        <= 1'b1;
            end
            if (row_any) begin
                bus.Row_Max <= row_cnt;
            end
            // Saturate on the last row so the counter never wraps within a frame.
            if (row_cnt != LAST_ROW) begin
                row_cnt <= row_cnt + ONE;
            end
        end else if ((state == FIND) && last_col && !seen) begin
            bus.Row_Min <= '0;
            bus.Row_Max <= '0;
        end
    end

    // Column pass: one accumulator bit per FIND cycle; first hit sets Col_Min,
    // every hit moves Col_Max. Empty is resolved on the final column.
    always_ff @(posedge GlobalClock or negedge Reset_n) begin
        if (!Reset_n) begin
            col_cnt     <= '0;
            col_seen    <= 1'b0;
            bus.Col_Min <= '0;
            bus.Col_Max <= '0;
            bus.Empty   <= 1'b0;
        end else if (state != FIND) begin
            col_cnt  <= '0;
            col_seen <= 1'b0;
        end else begin
            if (col_bit && !col_seen) begin
                bus.Col_Min <= col_cnt;
                col_seen    <= 1'b1;
            end
            if (col_bit) begin
                bus.Col_Max <= col_cnt;
            end
            if (!last_col) begin
                col_cnt <= col_cnt + ONE;
            end else begin
                bus.Empty <= !seen;
                // An empty frame leaves col_acc clear, so no load above competes
                // with this clear.
                if (!seen) begin
                    bus.Col_Min <= '0;
                    bus.Col_Max <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ink_bbox_scanner.sv
// Directed bench for ink_bbox_scanner: hand-built frames with hand-computed boxes,
// latency counted in clock edges, reset abort, stalls, Start masking and back-pressure.
module tb_ink_bbox_scanner;
    localparam int COLS  = 28;
    localparam int ROWS  = 28;
    localparam int IDX_W = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ink_bbox_scanner_if #(.COLS(COLS), .IDX_W(IDX_W)) bus ();

    ink_bbox_scanner #(.COLS(COLS), .ROWS(ROWS), .IDX_W(IDX_W)) dut (
        .GlobalClock (clk),
        .Reset_n     (rst_n),
        .bus         (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [COLS-1:0] fr [ROWS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic clr_frame();
        for (int r = 0; r < ROWS; r++) fr[r] = '0;
    endtask

    task automatic feed_row(input int r);
        bus.Row_Valid = 1'b1;
        bus.Row_Bits  = fr[r];
        @(negedge clk);
        bus.Row_Valid = 1'b0;
        bus.Row_Bits  = '0;
    endtask

    task automatic chk_box(input string tag, input int er0, input int er1,
                           input int ec0, input int ec1, input int ee);
        chk({tag, ".row_min"}, 32'(bus.Row_Min), er0);
        chk({tag, ".row_max"}, 32'(bus.Row_Max), er1);
        chk({tag, ".col_min"}, 32'(bus.Col_Min), ec0);
        chk({tag, ".col_max"}, 32'(bus.Col_Max), ec1);
        chk({tag, ".empty"},   32'(bus.Empty),   ee);
    endtask

    // One full frame from Start to handshake. ecyc is the Start-edge to Box_Valid
    // distance in clock edges (56 unstalled).
    task automatic run_frame(input string tag, input int gaps, input int hold,
                             input int start_hs, input int er0, input int er1,
                             input int ec0, input int ec1, input int ee, input int ecyc);
        int c0;
        int c_last;
        int k;
        @(negedge clk);
        chk({tag, ".idle_busy"}, 32'(bus.Busy), 0);
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        c0 = cyc;
        chk({tag, ".rdy"},  32'(bus.Row_Ready), 1);
        chk({tag, ".busy"}, 32'(bus.Busy), 1);
        for (int r = 0; r < ROWS; r++) begin
            if (gaps != 0) begin
                bus.Row_Valid = 1'b0;
                if (r == 10) bus.Start = 1'b1;
                @(negedge clk);
                bus.Start = 1'b0;
                if (r == 10) chk({tag, ".rdy_gap"}, 32'(bus.Row_Ready), 1);
            end
            feed_row(r);
        end
        c_last = cyc;
        chk({tag, ".rdy_lo"}, 32'(bus.Row_Ready), 0);
        k = 0;
        while (!bus.Box_Valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".bv_seen"},  32'(bus.Box_Valid), 1);
        chk({tag, ".lat_last"}, 32'(cyc - c_last), COLS);
        chk({tag, ".lat_start"}, 32'(cyc - c0), ecyc);
        chk_box(tag, er0, er1, ec0, ec1, ee);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, ".hold_bv"}, 32'(bus.Box_Valid), 1);
            chk({tag, ".hold_box"},
                32'({bus.Row_Min, bus.Row_Max, bus.Col_Min, bus.Col_Max, bus.Empty}),
                32'({5'(er0), 5'(er1), 5'(ec0), 5'(ec1), 1'(ee)}));
        end
        bus.Box_Ready = 1'b1;
        bus.Start     = (start_hs != 0);
        @(negedge clk);
        bus.Box_Ready = 1'b0;
        bus.Start     = 1'b0;
        chk({tag, ".bv_lo"},   32'(bus.Box_Valid), 0);
        chk({tag, ".busy_lo"}, 32'(bus.Busy), 0);
        @(negedge clk);
        chk({tag, ".no_start"}, 32'(bus.Row_Ready), 0);
        chk({tag, ".idle_box"},
            32'({bus.Row_Min, bus.Row_Max, bus.Col_Min, bus.Col_Max, bus.Empty}),
            32'({5'(er0), 5'(er1), 5'(ec0), 5'(ec1), 1'(ee)}));
    endtask

    initial begin
        bus.Start     = 1'b0;
        bus.Row_Valid = 1'b0;
        bus.Row_Bits  = '0;
        bus.Box_Ready = 1'b0;
        clr_frame();
        repeat (3) @(negedge clk);
        chk("rst.rdy",  32'(bus.Row_Ready), 0);
        chk("rst.bv",   32'(bus.Box_Valid), 0);
        chk("rst.busy", 32'(bus.Busy), 0);
        chk_box("rst", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Abort mid-scan: ink at row 2 has already set Row_Min before reset hits.
        fr[2][4] = 1'b1;
        @(negedge clk);
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        for (int r = 0; r < 10; r++) feed_row(r);
        chk("abort.pre_rmin", 32'(bus.Row_Min), 2);
        rst_n = 1'b0;
        #1;
        chk("abort.rdy",  32'(bus.Row_Ready), 0);
        chk("abort.busy", 32'(bus.Busy), 0);
        chk("abort.bv",   32'(bus.Box_Valid), 0);
        chk_box("abort", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single pixel (5,17) after the abort: only the new frame's box appears.
        clr_frame();
        fr[5][17] = 1'b1;
        run_frame("single", 0, 0, 0, 5, 5, 17, 17, 0, 56);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("single.no_2nd_bv", 32'(bus.Box_Valid), 0);
        end

        // Diagonal stroke.
        clr_frame();
        fr[3][3]   = 1'b1;
        fr[12][20] = 1'b1;
        fr[24][7]  = 1'b1;
        run_frame("diag", 0, 0, 0, 3, 24, 3, 20, 0, 56);

        // Empty frame clears the previous box.
        clr_frame();
        run_frame("zero", 0, 0, 0, 0, 0, 0, 0, 1, 56);

        // Full frame.
        for (int r = 0; r < ROWS; r++) fr[r] = '1;
        run_frame("full", 0, 0, 0, 0, 27, 0, 27, 0, 56);

        // Diagonal again with a gap before every row and a stray Start mid-scan.
        clr_frame();
        fr[3][3]   = 1'b1;
        fr[12][20] = 1'b1;
        fr[24][7]  = 1'b1;
        run_frame("stall", 1, 0, 0, 3, 24, 3, 20, 0, 84);

        // Back-pressure for 50 cycles, then Start alongside the handshake.
        clr_frame();
        fr[9][1]  = 1'b1;
        fr[14][26] = 1'b1;
        run_frame("hold", 0, 50, 1, 9, 14, 1, 26, 0, 56);

        // A fresh Start afterwards runs a normal frame.
        clr_frame();
        fr[27][0] = 1'b1;
        fr[0][27] = 1'b1;
        run_frame("fresh", 0, 0, 0, 0, 27, 0, 27, 0, 56);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ink_bbox_scanner.md
# ink_bbox_scanner

Scans one drawn canvas frame row by row and computes the bounding box of all inked pixels: first and last inked row, first and last inked column. Each row's any-pixel-set result is the wide OR reduction of that row's pixel bits, which is what the OR-gate stage provides. The block sits between the canvas frame buffer and the crop/centre stage that feeds the classifier. The result is held behind a valid/ready handshake until the downstream stage consumes it.

## Interface
- COLS, 28, pixels per row (width of Row_Bits)
- ROWS, 28, rows per frame
- IDX_W, 5, width of row/column indices; must satisfy 2^IDX_W >= max(ROWS, COLS)
- GlobalClock  in  1  single clock; all state updates on rising edge
- Reset_n  in  1  **one clock; reset is asynchronous and active-low**
- Start  in  1  begin a new frame; honoured only in IDLE
- Row_Valid  in  1  Row_Bits holds the next row
- Row_Ready  out  1  block accepts a row this cycle; high only in SCAN
- Row_Bits  in  COLS  pixel bits of the current row; bit c = column c
- Box_Valid  out  1  result registers are valid; high only in DONE
- Box_Ready  in  1  downstream consumes the result
- Row_Min, Row_Max  out  IDX_W  first and last inked row index
- Col_Min, Col_Max  out  IDX_W  first and last inked column index
- Empty  out  1  frame contained no inked pixel
- Busy  out  1  high in SCAN, FIND and DONE

## Operation
- States: IDLE, SCAN, FIND, DONE.
- Transitions:
  - IDLE -> SCAN on Start. Clears row counter, the column accumulator col_acc (COLS bits) and the seen flag.
  - SCAN -> FIND on the acceptance of row ROWS-1.
  - FIND -> DONE after column COLS-1 has been examined.
  - DONE -> IDLE on Box_Valid && Box_Ready.
- Start is ignored in SCAN, FIND and DONE.
- SCAN, per accepted row (Row_Valid && Row_Ready), with r = row counter:
  - row_any = OR of all Row_Bits.
  - col_acc <= col_acc | Row_Bits.
  - If row_any and !seen: Row_Min <= r and seen <= 1.
  - If row_any: Row_Max <= r.
  - r increments; it never wraps inside a frame.
- FIND examines one column per cycle, c = 0..COLS-1, from col_acc:
  - the first set bit loads Col_Min;
  - every set bit loads Col_Max.
- On entry to DONE:
  - Empty = !seen.
  - If Empty, Row_Min, Row_Max, Col_Min and Col_Max are all 0.
- Result registers are stable for the whole of DONE and do not change until the next frame's SCAN updates them.
- The IDX_W-bit indices are zero-extended. Row_Min <= Row_Max and Col_Min <= Col_Max always hold for a non-empty frame.
- Single-pixel frame: Min == Max on both axes.

## Timing
- Reset (async assert, sync deassert handled upstream): state = IDLE and every output = 0, i.e. Row_Ready, Box_Valid, Busy, Empty and all indices.
- Reset asserted mid-frame aborts immediately. The partial result is discarded and no Box_Valid is issued.
- All outputs are registered; there is no combinational path from input to output.
- Start sampled high in IDLE: SCAN, Row_Ready=1 and Busy=1 from the next cycle.
- Row acceptance:
  - Row_Ready stays high in SCAN regardless of Row_Valid.
  - Gaps (Row_Valid=0) stall the scan with no state change.
  - Minimum frame time is ROWS cycles.
- FIND is entered on the edge that accepts row ROWS-1. Row_Ready is low from that edge.
- FIND lasts exactly COLS cycles. Box_Valid rises COLS cycles after the last-row acceptance edge.
- Box_Valid held with Box_Ready low: all results stay frozen indefinitely.
- Handshake in DONE: the result is consumed at the edge where Box_Valid && Box_Ready. Box_Valid and Busy are low the next cycle and state is IDLE.
- Start asserted in that same cycle is ignored; it must be presented again in IDLE.
- Fastest frame-to-frame turnaround: ROWS + COLS + 2 cycles.

## Test plan
- Reset with Reset_n=0 mid-SCAN after 10 rows -> all outputs 0 immediately. After release, Start plus 28 clean rows yield only one Box_Valid, reflecting the new frame alone.
- Single pixel at row 5, column 17, all other rows zero, Box_Ready=1 -> Row_Min=Row_Max=5, Col_Min=Col_Max=17, Empty=0. Box_Valid rises 28 cycles after the last-row edge and lasts 1 cycle.
- Diagonal stroke: pixels (3,3), (12,20), (24,7) -> Row_Min=3, Row_Max=24, Col_Min=3, Col_Max=20.
- All-zero frame -> Empty=1 and all four indices 0. Full frame (all bits 1) -> 0/27/0/27, Empty=0.
- Row_Valid toggled 1/0 each cycle, plus a Start pulse mid-SCAN -> same result as the unstalled case, Start has no effect, and Box_Valid is delayed by exactly the 28 gap cycles.
- Box_Ready held 0 for 50 cycles in DONE -> Box_Valid and results frozen throughout. Box_Ready=1 with Start=1 in the same cycle -> IDLE with Start ignored; the next Start begins a fresh frame.
